aes_key_schedule: RTL

Sequential AES-128 key expansion stage that sits directly upstream of the `round` block. It loads a 128-bit cipher key and presents round keys 0 through 10 one at a time, each behind a valid/ready handshake. Each new key is derived from the previous one over a two-cycle registered expansion step. `key_out` drives the round's `key` input, and `last_round` drives its `skip_mix_cols`.

---
 rtl/aes_pkg.sv | 27 ++
 rtl/aes_sbox.sv | 29 ++
 rtl/aes_key_schedule.sv | 120 ++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 definitions for the key schedule and the round datapath.
package aes_pkg;

  localparam int NUM_ROUNDS = 10;

  typedef logic [127:0] key_t;
  typedef logic [31:0]  word_t;

  // Key schedule FSM states; exposed on the debug port of aes_key_schedule.
  typedef enum logic [1:0] {
    KS_IDLE   = 2'd0,
    KS_HOLD   = 2'd1,
    KS_EXPAND = 2'd2
  } ks_state_t;

  // Round constants, indexed by the round being produced (1..10).
  localparam logic [7:0] RCON [1:10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  // RotWord({a,b,c,d}) = {b,c,d,a}
  function automatic word_t rot_word(input word_t w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, one byte in, one byte out.
module aes_sbox (
  input  logic [7:0] value,
  output logic [7:0] subst
);

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Table lookup; the full byte range is covered so there is no default path.
  assign subst = SBOX[value];

endmodule

// File: rtl/aes_key_schedule.sv
// Sequential AES-128 key expansion: presents round keys 0..10, one per
// handshake, each new key derived over a two-cycle HOLD -> EXPAND step.
//
// Handshake: a key transfers on a rising edge where key_valid && key_ready.
// key_valid never depends on key_ready; while key_valid && !key_ready,
// key_out and round_idx hold. key_ready is ignored while key_valid is low.
module aes_key_schedule
  import aes_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [127:0] key_in,
  input  logic        key_ready,
  output logic [127:0] key_out,
  output logic        key_valid,
  output logic [3:0]  round_idx,
  output logic        last_round,
  output logic        busy,
  output logic        done,
  output ks_state_t   state_dbg
);

  localparam logic [1:0] IDLE   = KS_IDLE;
  localparam logic [1:0] HOLD   = KS_HOLD;
  localparam logic [1:0] EXPAND = KS_EXPAND;

  localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS);

  logic [1:0] state;
  key_t       key_reg;
  word_t      temp;
  logic [3:0] round_q;
  logic       done_q;

  word_t      w0, w1, w2, w3;
  word_t      rot_w3;
  word_t      sub_w3;
  logic [3:0] rc_idx;
  logic [7:0] rcon_byte;
  word_t      temp_next;
  word_t      n0, n1, n2, n3;

  assign w0 = key_reg[127:96];
  assign w1 = key_reg[95:64];
  assign w2 = key_reg[63:32];
  assign w3 = key_reg[31:0];

  assign rot_w3 = rot_word(w3);

  aes_sbox u_sbox0 (.value(rot_w3[31:24]), .subst(sub_w3[31:24]));
  aes_sbox u_sbox1 (.value(rot_w3[23:16]), .subst(sub_w3[23:16]));
  aes_sbox u_sbox2 (.value(rot_w3[15:8]),  .subst(sub_w3[15:8]));
  aes_sbox u_sbox3 (.value(rot_w3[7:0]),   .subst(sub_w3[7:0]));

  // Round constant for the key about to be produced; zero once the last key
  // is out so the table is never indexed past its end.
  always_comb begin
    rc_idx    = round_q + 4'd1;
    rcon_byte = 8'h00;
    if (round_q < LAST_IDX) begin
      rcon_byte = RCON[rc_idx];
    end
  end

  assign temp_next = sub_w3 ^ {rcon_byte, 24'h000000};

  // Word XOR chain for the EXPAND step, using temp captured in HOLD.
  assign n0 = w0 ^ temp;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  // FSM, key register and round counter; start overrides every state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      key_reg <= '0;
      temp    <= '0;
      round_q <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        key_reg <= key_in;
        round_q <= '0;
        state   <= HOLD;
      end else begin
        case (state)
          HOLD: begin
            if (key_ready) begin
              if (round_q < LAST_IDX) begin
                temp  <= temp_next;
                state <= EXPAND;
              end else begin
                done_q <= 1'b1;
                state  <= IDLE;
              end
            end
          end
          EXPAND: begin
            key_reg <= {n0, n1, n2, n3};
            round_q <= round_q + 4'd1;
            state   <= HOLD;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign key_out    = key_reg;
  assign key_valid  = (state == HOLD);
  assign round_idx  = round_q;
  assign last_round = key_valid && (round_q == LAST_IDX);
  assign busy       = (state != IDLE);
  assign done       = done_q;
  assign state_dbg  = ks_state_t'(state);

endmodule
